// File: rtl/md_pkg.sv
// Shared opcodes, default latencies and result type for the multiply/divide unit.
// MD_MADD_EN enables the madd/maddu accumulate opcodes.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [2:0] MD_MADD  = 3'd6;
  localparam logic [2:0] MD_MADDU = 3'd7;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

  localparam int unsigned MD_RES_W = 64;
  typedef logic [MD_RES_W-1:0] md_res_t;

  // Ops that occupy the unit for several cycles and therefore stall decode.
  function automatic logic md_is_multi(logic [2:0] op);
    logic r;
    r = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`ifdef MD_MADD_EN
    r = r || (op == MD_MADD) || (op == MD_MADDU);
`endif
    return r;
  endfunction

  function automatic logic md_is_div(logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational product/quotient/remainder for the multiply/divide unit.
// MD_MADD_EN adds the {hi,lo} accumulate path for madd/maddu.
module md_calc
  import md_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_by_zero
);

  logic        w_signed;
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic [63:0] w_prod;
  logic [31:0] w_dvd;
  logic [31:0] w_dvs;
  logic [31:0] w_quo_u;
  logic [31:0] w_rem_u;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  md_res_t     w_res;

  assign w_signed = (md_op == MD_MULT) || (md_op == MD_DIV) || (md_op == MD_MADD);

  // Sign-extending to 64 bits lets one unsigned multiplier serve both flavours.
  assign w_ext_a = {{32{w_signed & src_a[31]}}, src_a};
  assign w_ext_b = {{32{w_signed & src_b[31]}}, src_b};
  assign w_prod  = w_ext_a * w_ext_b;

  // Signed divide runs on magnitudes; 0x80000000/-1 then falls out as 0x80000000 rem 0.
  assign div_by_zero = (src_b == 32'd0);
  assign w_dvd   = (w_signed && src_a[31]) ? (32'd0 - src_a) : src_a;
  assign w_dvs   = div_by_zero ? 32'd1 :
                   ((w_signed && src_b[31]) ? (32'd0 - src_b) : src_b);
  assign w_quo_u = w_dvd / w_dvs;
  assign w_rem_u = w_dvd % w_dvs;
  assign w_quo   = (w_signed && (src_a[31] ^ src_b[31])) ? (32'd0 - w_quo_u) : w_quo_u;
  assign w_rem   = (w_signed && src_a[31]) ? (32'd0 - w_rem_u) : w_rem_u;

  always_comb begin
    w_res = {hi, lo};
    unique case (md_op)
      MD_MULT, MD_MULTU: w_res = w_prod;
      MD_DIV, MD_DIVU:   w_res = {w_rem, w_quo};
`ifdef MD_MADD_EN
      MD_MADD, MD_MADDU: w_res = {hi, lo} + w_prod;
`endif
      default:           w_res = {hi, lo};
    endcase
  end

  assign res_hi = w_res[63:32];
  assign res_lo = w_res[31:0];

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding HI/LO, with a stall hazard for decode.
// MD_MADD_EN enables madd/maddu (accumulate into HI/LO).
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        md_hazard,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CntMax = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  logic [CntW-1:0] r_cnt;
  logic [31:0]     r_hi;
  logic [31:0]     r_lo;
  logic [31:0]     r_res_hi;
  logic [31:0]     r_res_lo;
  logic            r_res_wr;

  logic            w_accept;
  logic            w_multi;
  logic [31:0]     w_res_hi;
  logic [31:0]     w_res_lo;
  logic            w_div_by_zero;

  md_calc u_md_calc (
    .md_op       (md_op),
    .src_a       (src_a),
    .src_b       (src_b),
    .hi          (r_hi),
    .lo          (r_lo),
    .res_hi      (w_res_hi),
    .res_lo      (w_res_lo),
    .div_by_zero (w_div_by_zero)
  );

  assign busy      = (r_cnt != '0);
  assign w_multi   = md_is_multi(md_op);
  assign w_accept  = start & ~busy;
  assign md_hazard = busy | (start & w_multi);
  assign hi        = r_hi;
  assign lo        = r_lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_res_hi <= '0;
      r_res_lo <= '0;
      r_res_wr <= 1'b0;
    end else if (busy) begin
      r_cnt <= r_cnt - 1'b1;
      if ((r_cnt == CntW'(1)) && r_res_wr) begin
        r_hi <= r_res_hi;
        r_lo <= r_res_lo;
      end
    end else if (w_accept) begin
      if (w_multi) begin
        r_cnt    <= md_is_div(md_op) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
        r_res_hi <= w_res_hi;
        r_res_lo <= w_res_lo;
        // A zero divisor still occupies the unit but must leave HI/LO alone.
        r_res_wr <= ~(md_is_div(md_op) & w_div_by_zero);
      end else if (md_op == MD_MTHI) begin
        r_hi <= src_a;
      end else if (md_op == MD_MTLO) begin
        r_lo <= src_a;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vector table, corner sequences, random vs model.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        md_hazard;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  localparam int MC = 5;
  localparam int DC = 10;

  md_unit #(
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .md_op     (md_op),
    .src_a     (src_a),
    .src_b     (src_b),
    .busy      (busy),
    .md_hazard (md_hazard),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    int          cyc;
    logic        haz;
    string       nm;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Architectural model: what HI/LO become, how long the unit is busy, whether decode stalls.
  task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        inout logic [31:0] h, inout logic [31:0] l,
                        output int cyc, output logic haz);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    cyc = 0;
    haz = 1'b0;
    case (op)
      3'd0: begin p = sa * sb; {h, l} = p; cyc = MC; haz = 1'b1; end
      3'd1: begin p = ua * ub; {h, l} = p; cyc = MC; haz = 1'b1; end
      3'd2: begin
        cyc = DC; haz = 1'b1;
        if (b != 0) begin q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0]; end
      end
      3'd3: begin
        cyc = DC; haz = 1'b1;
        if (b != 0) begin h = 32'(ua % ub); l = 32'(ua / ub); end
      end
      3'd4: h = a;
      3'd5: l = a;
`ifdef MD_MADD_EN
      3'd6: begin p = {h, l} + longint'(sa * sb); {h, l} = p; cyc = MC; haz = 1'b1; end
      3'd7: begin p = {h, l} + ua * ub; {h, l} = p; cyc = MC; haz = 1'b1; end
`endif
      default: ;
    endcase
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input int ecyc,
                       input logic ehaz, input string nm);
    logic [31:0] h0, l0;
    int cyc;
    @(negedge clk);
    h0 = hi;
    l0 = lo;
    start = 1'b1; md_op = op; src_a = a; src_b = b;
    #1;
    chk({nm, "_haz"}, 32'(md_hazard), 32'(ehaz));
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!busy || cyc > 100) break;
      cyc++;
      chk({nm, "_hold"}, {hi[15:0], lo[15:0]} ^ {h0[15:0], l0[15:0]}, 32'd0);
    end
    chk({nm, "_cyc"}, 32'(cyc), 32'(ecyc));
    chk({nm, "_hi"}, hi, eh);
    chk({nm, "_lo"}, lo, el);
  endtask

  function automatic vec_t mk(logic [2:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] eh,
                              logic [31:0] el, int cyc, logic haz, string nm);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.eh = eh; v.el = el; v.cyc = cyc; v.haz = haz; v.nm = nm;
    return v;
  endfunction

  initial begin
    int cyc;
    logic haz;
    logic [31:0] a, b;
    logic [2:0] op;

    reset = 1'b1; start = 1'b0; md_op = 3'd0; src_a = '0; src_b = '0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_haz_idle", 32'(md_hazard), 32'd0);
    start = 1'b1;
    #1;
    chk("rst_haz_start", 32'(md_hazard), 32'd1);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    vecs.push_back(mk(3'd0, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, MC, 1, "mult"));
    vecs.push_back(mk(3'd1, 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFE, MC, 1, "multu"));
    vecs.push_back(mk(3'd2, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, DC, 1, "div"));
    vecs.push_back(mk(3'd3, 32'h7, 32'h2, 32'h1, 32'h3, DC, 1, "divu"));
    vecs.push_back(mk(3'd4, 32'hA, 32'h0, 32'hA, 32'h3, 0, 0, "mthi_a"));
    vecs.push_back(mk(3'd5, 32'hB, 32'h0, 32'hA, 32'hB, 0, 0, "mtlo_b"));
    vecs.push_back(mk(3'd2, 32'h5, 32'h0, 32'hA, 32'hB, DC, 1, "div0"));
    vecs.push_back(mk(3'd3, 32'h5, 32'h0, 32'hA, 32'hB, DC, 1, "divu0"));
    vecs.push_back(mk(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, DC, 1, "divovf"));
    vecs.push_back(mk(3'd4, 32'h12345678, 32'h0, 32'h12345678, 32'h80000000, 0, 0, "mthi"));
    vecs.push_back(mk(3'd5, 32'h9ABCDEF0, 32'h0, 32'h12345678, 32'h9ABCDEF0, 0, 0, "mtlo"));
    vecs.push_back(mk(3'd4, 32'h0, 32'h0, 32'h0, 32'h9ABCDEF0, 0, 0, "mthi0"));
    vecs.push_back(mk(3'd5, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 0, "mtlo1"));
`ifdef MD_MADD_EN
    vecs.push_back(mk(3'd7, 32'h1, 32'h1, 32'h1, 32'h0, MC, 1, "maddu"));
`else
    vecs.push_back(mk(3'd7, 32'h1, 32'h1, 32'h0, 32'hFFFFFFFF, 0, 0, "maddu_off"));
`endif

    foreach (vecs[i])
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el, vecs[i].cyc,
            vecs[i].haz, vecs[i].nm);

    // Reset in the third busy cycle of a multiply aborts it.
    @(negedge clk);
    start = 1'b1; md_op = 3'd0; src_a = 32'h3; src_b = 32'h4;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_haz", 32'(md_hazard), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_late_busy", 32'(busy), 32'd0);
    chk("abort_late_lo", lo, 32'd0);

    // A start held into the busy window must be ignored.
    @(negedge clk);
    start = 1'b1; md_op = 3'd3; src_a = 32'd7; src_b = 32'd2;
    @(posedge clk);
    #1 md_op = 3'd4; src_a = 32'h55;
    #1;
    chk("ign_haz", 32'(md_hazard), 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!busy || cyc > 100) break;
      cyc++;
    end
    chk("ign_cyc", 32'(cyc), 32'(DC - 1));
    chk("ign_hi", hi, 32'h1);
    chk("ign_lo", lo, 32'h3);

    m_hi = 32'h1;
    m_lo = 32'h3;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      ref_op(op, a, b, m_hi, m_lo, cyc, haz);
      do_op(op, a, b, m_hi, m_lo, cyc, haz, $sformatf("rnd%0d_op%0d", i, op));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
